ntt_loop_sequencer: RTL
=======================

// Module: ntt_loop_sequencer
// PURPOSE
//  Loop-control FSM driving the NTT/INTT pipelined address generator. On a start
//  pulse it walks all LOG_N stages and N/2 beats per stage, one beat per cycle,
//  presenting i, j, m, counter and current_pair with a one-cycle enable strobe.
//  Between stages it inserts a hazard gap; after the last stage it drains the
//  address pipeline, then pulses done.
// PARAMETERS
//  N            256  transform length (power of 2, >=8)
//  N_bits       8    log2(N); also LOG_N = N_bits stages
//  STAGE_GAP    4    idle cycles between stages (butterfly write-back hazard); 0 allowed
//  DRAIN_CYCLES 2    cycles after last beat before done (address-generator latency)
// PORTS
//  clk          in   1         clock
//  reset        in   1         synchronous, active-high
//  start        in   1         begin transform; sampled only in IDLE
//  start_intt   in   1         mode, latched with start (1 = INTT)
//  hold         in   1         downstream stall; freezes beat issue
//  enable       out  1         beat valid to address generator
//  is_intt      out  1         latched mode
//  i            out  N_bits+1  stage index 0..LOG_N-1
//  j            out  N_bits+1  current group base
//  m            out  N_bits+1  1 << (i+1)
//  counter      out  N_bits+1  first coefficient index of beat
//  current_pair out  N_bits+1  twiddle index within group
//  stage_last   out  1         enable beat is last of its stage
//  busy         out  1         state != IDLE
//  done         out  1         one-cycle completion pulse
// BEHAVIOUR
//  - Reset: state IDLE, all outputs/counters 0; reset mid-operation aborts, no done.
//  - States:
//    - IDLE: start=1 latches start_intt, clears i/j/k/beat, goes to RUN.
//    - RUN: issue beats; after final beat of stage go to GAP (i<LOG_N-1, STAGE_GAP>0),
//      RUN with i+1 (STAGE_GAP=0), or DRAIN (i=LOG_N-1).
//    - GAP: STAGE_GAP cycles, then i<=i+1, j/k/beat cleared, RUN.
//    - DRAIN: DRAIN_CYCLES cycles, then DONE.
//    - DONE: done=1 one cycle, then IDLE.
//  - enable = (state==RUN) && !hold, combinational in hold; other outputs registered.
//  - Beat consumed iff enable=1; only then do counters advance. hold=1 freezes all
//    outputs. hold is ignored outside RUN, so GAP/DRAIN counters do not stall.
//  - Beat addressing, N/2 beats per stage:
//    - i<2: counter = 2*beat (0,2,..,N-2); j = counter; current_pair = 0.
//    - i>=2: half = m>>2 = 2^(i-1); k = 0..half-1 inner; j steps by 2^i outer.
//      counter = j+k; current_pair = k.
//  - stage_last = enable && beat==N/2-1.
//  - Total beats = LOG_N*N/2 (1024 at N=256). start while busy is ignored;
//    start_intt is sampled only with an accepted start.
//  - Latency: start at cycle T -> first enable at T+1 (hold=0). Last beat at
//    T + LOG_N*N/2 + (LOG_N-1)*STAGE_GAP; done is DRAIN_CYCLES+1 cycles later.
//  - All arithmetic is unsigned N_bits+1 wide; m=N at the last stage must not wrap.
// TESTING
//  1. Reset, then start=1 start_intt=0, hold=0 -> enable from next cycle; i=0
//     counters 0,2,4..254; 128 beats; stage_last on beat 127; 4 gap cycles.
//  2. Stage i=2 -> m=8; counter 0,1,4,5,8,9..; current_pair 0,1,0,1; j 0,0,4,4.
//     Stage 7 -> m=256; counter 0..63 then 128..191; j 0 then 128.
//  3. Full run, N=256 defaults -> 1024 enables; done exactly once at cycle
//     T+1+1024+28+2; busy low next cycle; is_intt tracks start_intt=1 run.
//  4. hold=1 for 3 cycles mid-stage-3 -> enable=0 and outputs frozen; sequence
//     resumes with no skipped/duplicated beat; done delayed by 3 cycles.
//  5. start pulsed during RUN -> ignored, no restart; reset asserted at beat 500 ->
//     next cycle IDLE, outputs 0, no done; new start runs cleanly from i=0.
//  6. STAGE_GAP=0, N=16 -> stages back-to-back; 32 beats; final i=3, m=16.

Source files
------------

// File: rtl/ntt_loop_sequencer.sv
// ntt_loop_sequencer
//   Loop-control FSM for the NTT/INTT pipelined address generator. A start
//   pulse walks LOG_N = N_bits stages of N/2 beats each, one beat per cycle,
//   with a STAGE_GAP idle window between stages for butterfly write-back and
//   a DRAIN_CYCLES window after the final beat before a one-cycle done pulse.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             begin a transform (accepted only while idle)
//   start_intt        transform mode, latched with an accepted start
//   hold              downstream stall; freezes beat issue while running
//   enable            beat valid (combinational in hold)
//   is_intt           latched mode
//   i, j, m           stage index, group base, 1 << (i+1)
//   counter           first coefficient index of the beat (j + k)
//   current_pair      twiddle index within the group (k)
//   stage_last        enable beat is the last of its stage
//   busy, done        not idle / one-cycle completion pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | issuing beats of stage i
// S_GAP   | write-back hazard window between stages
// S_DRAIN | waiting for the address pipeline to empty after the last beat
// S_DONE  | done pulse, back to idle next cycle

module ntt_loop_sequencer #(
  parameter int N            = 256,
  parameter int N_bits       = 8,
  parameter int STAGE_GAP    = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            start_intt,
  input  logic            hold,
  output logic            enable,
  output logic            is_intt,
  output logic [N_bits:0] i,
  output logic [N_bits:0] j,
  output logic [N_bits:0] m,
  output logic [N_bits:0] counter,
  output logic [N_bits:0] current_pair,
  output logic            stage_last,
  output logic            busy,
  output logic            done
);

  localparam int W = N_bits + 1;
  localparam logic [W-1:0] BEAT_LAST  = W'(N / 2 - 1);
  localparam logic [W-1:0] I_LAST     = W'(N_bits - 1);
  localparam logic [15:0]  GAP_LOAD   = 16'(STAGE_GAP > 0 ? STAGE_GAP - 1 : 0);
  localparam logic [15:0]  DRAIN_LOAD = 16'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   i_q, i_d;
  logic [W-1:0]   j_q, j_d;
  logic [W-1:0]   k_q, k_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   beat_q, beat_d;
  logic           intt_q, intt_d;
  logic [15:0]    tmr_q, tmr_d;
  logic [W-1:0]   k_last;

  // Last inner index of a group for stages i >= 2: half - 1 = (m >> 2) - 1.
  assign k_last = (m_q >> 2) - W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      beat_q  <= '0;
      intt_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      m_q     <= m_d;
      beat_q  <= beat_d;
      intt_q  <= intt_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    m_d        = m_q;
    beat_d     = beat_q;
    intt_d     = intt_q;
    tmr_d      = tmr_q;
    enable     = (state_q == S_RUN) && !hold;
    stage_last = enable && (beat_q == BEAT_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          intt_d  = start_intt;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          beat_d  = '0;
          m_d     = W'(2);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (enable) begin
          if (beat_q == BEAT_LAST) begin
            if (i_q == I_LAST) begin
              if (DRAIN_CYCLES > 0) begin
                tmr_d   = DRAIN_LOAD;
                state_d = S_DRAIN;
              end else begin
                state_d = S_DONE;
              end
            end else if (STAGE_GAP > 0) begin
              tmr_d   = GAP_LOAD;
              state_d = S_GAP;
            end else begin
              // no hazard window: next stage starts on the following cycle
              i_d    = i_q + W'(1);
              m_d    = m_q << 1;
              j_d    = '0;
              k_d    = '0;
              beat_d = '0;
            end
          end else begin
            beat_d = beat_q + W'(1);
            // stages 0 and 1 walk even coefficients; k stays at 0
            if (i_q < W'(2)) begin
              j_d = j_q + W'(2);
            end else if (k_q == k_last) begin
              k_d = '0;
              j_d = j_q + (m_q >> 1);
            end else begin
              k_d = k_q + W'(1);
            end
          end
        end
      end

      S_GAP: begin
        if (tmr_q == '0) begin
          i_d     = i_q + W'(1);
          m_d     = m_q << 1;
          j_d     = '0;
          k_d     = '0;
          beat_d  = '0;
          state_d = S_RUN;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end

      S_DRAIN: begin
        if (tmr_q == '0) state_d = S_DONE;
        else             tmr_d   = tmr_q - 16'd1;
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign is_intt      = intt_q;
  assign i            = i_q;
  assign j            = j_q;
  assign m            = m_q;
  assign counter      = j_q + k_q;
  assign current_pair = k_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule
